// File: rtl/mem_read_b_pkg.sv
// Shared definitions for the B-matrix reader: FSM state encoding, read-latency bounds
// and the bank/layout constants it shares with the B writer.
package mem_read_b_pkg;

   // B layout: element (r, p*N2+x) lives in bank x at address p*M2+r.
   localparam int unsigned N2_DEF     = 4;
   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;

   // Fields of the out_valid/out_first/out_last delay line.
   localparam int unsigned PIPE_W     = 3;
   localparam int unsigned PIPE_VALID = 2;
   localparam int unsigned PIPE_FIRST = 1;
   localparam int unsigned PIPE_LAST  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/mem_read_b_delay_line.sv
// Fixed-depth shift register; aligns read-side flags with the bank output data.
module delay_line #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= din;
         for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/mem_read_b.sv
// B-matrix reader: replays all column tiles of B once per A row tile, issuing one
// common address to every bank and flagging the first/last row of each tile.
//
// state    | meaning
// ST_IDLE  | waiting for start; sizes are latched here
// ST_RUN   | issuing reads, one per non-stalled cycle
// ST_DRAIN | last read issued, waiting RD_LAT cycles for its data
module mem_read_b
   import mem_read_b_pkg::*;
#(
   parameter int unsigned N2           = N2_DEF,
   parameter int unsigned MATRIXSIZE_W = 16,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned RD_LAT       = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [MATRIXSIZE_W-1:0] M2,
   input  logic [MATRIXSIZE_W-1:0] M3dN2,
   input  logic [MATRIXSIZE_W-1:0] M1dN1,
   input  logic                    start,
   input  logic                    stall,
   output logic                    rd_en_B,
   output logic [ADDR_W-1:0]       rd_addr_B,
   output logic                    out_valid,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   if (N2 < 1 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_param_check
      $error("mem_read_b: N2 must be >= 1 and RD_LAT must lie in 1..4");
   end

   localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

   rd_state_t               state;
   logic [MATRIXSIZE_W-1:0] m2_q, m3_q, m1_q;
   logic [MATRIXSIZE_W-1:0] r_cnt, p_cnt, i_cnt;
   logic [ADDR_W-1:0]       offset;
   logic [1:0]              drain_cnt;
   logic                    r_last, p_last, i_last, sizes_ok;
   logic [PIPE_W-1:0]       pipe_in, pipe_out;

   assign sizes_ok = (M2 != '0) && (M3dN2 != '0) && (M1dN1 != '0);
   assign r_last   = (r_cnt == m2_q - ONE);
   assign p_last   = (p_cnt == m3_q - ONE);
   assign i_last   = (i_cnt == m1_q - ONE);

   // Reads are only issued in RUN and are suppressed combinationally by stall.
   assign rd_en_B   = (state == ST_RUN) && !stall;
   assign rd_addr_B = offset + ADDR_W'(r_cnt);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         m2_q      <= '0;
         m3_q      <= '0;
         m1_q      <= '0;
         r_cnt     <= '0;
         p_cnt     <= '0;
         i_cnt     <= '0;
         offset    <= '0;
         drain_cnt <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (sizes_ok) begin
                     m2_q   <= M2;
                     m3_q   <= M3dN2;
                     m1_q   <= M1dN1;
                     r_cnt  <= '0;
                     p_cnt  <= '0;
                     i_cnt  <= '0;
                     offset <= '0;
                     state  <= ST_RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  if (r_last && p_last && i_last) begin
                     r_cnt     <= '0;
                     p_cnt     <= '0;
                     i_cnt     <= '0;
                     offset    <= '0;
                     drain_cnt <= 2'(RD_LAT - 1);
                     state     <= ST_DRAIN;
                  end else if (r_last) begin
                     r_cnt <= '0;
                     if (p_last) begin
                        p_cnt  <= '0;
                        offset <= '0;
                        i_cnt  <= i_cnt + ONE;
                     end else begin
                        p_cnt  <= p_cnt + ONE;
                        offset <= offset + ADDR_W'(m2_q);
                     end
                  end else begin
                     r_cnt <= r_cnt + ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 2'd0) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Flags are gated by rd_en_B so they never appear without a valid beat.
   assign pipe_in[PIPE_VALID] = rd_en_B;
   assign pipe_in[PIPE_FIRST] = rd_en_B && (r_cnt == '0);
   assign pipe_in[PIPE_LAST]  = rd_en_B && r_last;

   delay_line #(
      .WIDTH (PIPE_W),
      .DEPTH (RD_LAT)
   ) u_delay_line (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pipe_in),
      .dout  (pipe_out)
   );

   assign out_valid = pipe_out[PIPE_VALID];
   assign out_first = pipe_out[PIPE_FIRST];
   assign out_last  = pipe_out[PIPE_LAST];

endmodule

// File: tb/tb_mem_read_b.sv
// Directed bench for mem_read_b: expected reads and output beats are queued from a
// loop model of the issue order, then popped as the DUT produces them.
module tb_mem_read_b;

   localparam int N2 = 4;
   localparam int MW = 16;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [MW-1:0] m2, m3, m1;
   logic          start_a, start_b, stall;

   logic          a_en, a_valid, a_first, a_last, a_busy, a_done;
   logic [AW-1:0] a_addr;
   logic          b_en, b_valid, b_first, b_last, b_busy, b_done;
   logic [AW-1:0] b_addr;

   always #5 clk = ~clk;

   mem_read_b #(.N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW), .RD_LAT(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .M2(m2), .M3dN2(m3), .M1dN1(m1),
      .start(start_a), .stall(stall), .rd_en_B(a_en), .rd_addr_B(a_addr),
      .out_valid(a_valid), .out_first(a_first), .out_last(a_last),
      .busy(a_busy), .done(a_done));

   mem_read_b #(.N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW), .RD_LAT(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .M2(m2), .M3dN2(m3), .M1dN1(m1),
      .start(start_b), .stall(stall), .rd_en_B(b_en), .rd_addr_B(b_addr),
      .out_valid(b_valid), .out_first(b_first), .out_last(b_last),
      .busy(b_busy), .done(b_done));

   logic          sel_b;
   logic          o_en, o_valid, o_first, o_last, o_busy, o_done;
   logic [AW-1:0] o_addr;
   assign o_en    = sel_b ? b_en    : a_en;
   assign o_addr  = sel_b ? b_addr  : a_addr;
   assign o_valid = sel_b ? b_valid : a_valid;
   assign o_first = sel_b ? b_first : a_first;
   assign o_last  = sel_b ? b_last  : a_last;
   assign o_busy  = sel_b ? b_busy  : a_busy;
   assign o_done  = sel_b ? b_done  : a_done;

   // Bank model standing in for the B writer's memories, with a read pipeline.
   logic [15:0] bank [N2][64];
   logic [63:0] bp [4];
   always @(posedge clk) begin
      bp[0] <= {bank[3][o_addr[5:0]], bank[2][o_addr[5:0]],
                bank[1][o_addr[5:0]], bank[0][o_addr[5:0]]};
      for (int k = 1; k < 4; k++) bp[k] <= bp[k-1];
   end

   typedef struct {int cyc; logic [AW-1:0] addr;} rd_t;
   typedef struct {int cyc; logic first; logic last; logic [63:0] data;} out_t;
   rd_t  rq[$];
   out_t oq[$];

   int vecs = 0;
   int errs = 0;

   function automatic logic [15:0] elem(input int r, input int col);
      return {r[7:0], col[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, o_en, 1'b0);
      chk({tag, "_rd_addr"}, o_addr, '0);
      chk({tag, "_out_valid"}, o_valid, 1'b0);
      chk({tag, "_out_first"}, o_first, 1'b0);
      chk({tag, "_out_last"}, o_last, 1'b0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
   endtask

   task automatic run_case(input int cm2, input int cm3, input int cm1,
                           input int st_lo, input int st_hi, input int lat,
                           input bit use_b, input int restart_cyc);
      int c, done_cyc, nreads;
      bit in_st;
      logic [63:0] d;
      sel_b = use_b;
      for (int x = 0; x < N2; x++)
         for (int a = 0; a < 64; a++) bank[x][a] = 16'hdead;
      for (int p = 0; p < cm3; p++)
         for (int r = 0; r < cm2; r++)
            for (int x = 0; x < N2; x++) bank[x][(p*cm2 + r) % 64] = elem(r, p*N2 + x);
      c = 1;
      nreads = 0;
      for (int i = 0; i < cm1; i++)
         for (int p = 0; p < cm3; p++)
            for (int r = 0; r < cm2; r++) begin
               while (c >= st_lo && c <= st_hi) c++;
               d = {elem(r, p*N2+3), elem(r, p*N2+2), elem(r, p*N2+1), elem(r, p*N2)};
               rq.push_back('{c, AW'(p*cm2 + r)});
               oq.push_back('{c + lat, (r == 0), (r == cm2 - 1), d});
               c++;
               nreads++;
            end
      done_cyc = (nreads > 0) ? c + lat : 1;

      for (int cyc = 0; cyc <= done_cyc + 3; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 0) begin
            m2 = MW'(cm2); m3 = MW'(cm3); m1 = MW'(cm1);
         end else begin
            m2 = 16'd9; m3 = 16'd9; m1 = 16'd9;
         end
         in_st   = (cyc >= st_lo && cyc <= st_hi);
         stall   = in_st;
         start_a = !use_b && (cyc == 0 || cyc == restart_cyc);
         start_b =  use_b && (cyc == 0 || cyc == restart_cyc);
         @(negedge clk);
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("rd_en", o_en, 1'b1);
            chk("rd_addr", o_addr, rq[0].addr);
            void'(rq.pop_front());
         end else begin
            chk("rd_en_low", o_en, 1'b0);
            if (in_st && cyc >= 1 && rq.size() > 0) chk("hold_addr", o_addr, rq[0].addr);
         end
         if (oq.size() > 0 && oq[0].cyc == cyc) begin
            chk("out_valid", o_valid, 1'b1);
            chk("out_first", o_first, oq[0].first);
            chk("out_last", o_last, oq[0].last);
            chk("bank_data", bp[lat-1], oq[0].data);
            void'(oq.pop_front());
         end else begin
            chk("out_valid_low", o_valid, 1'b0);
         end
         chk("done", o_done, (cyc == done_cyc));
         chk("busy", o_busy, (nreads > 0 && cyc >= 1 && cyc < done_cyc));
      end
      chk("reads_left", rq.size(), 0);
      chk("beats_left", oq.size(), 0);
      rq.delete();
      oq.delete();
      start_a = 1'b0;
      start_b = 1'b0;
      stall   = 1'b0;
   endtask

   initial begin
      sel_b = 1'b0; rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; stall = 1'b0;
      m2 = '0; m3 = '0; m1 = '0;
      #2;
      chk_idle_outputs("reset_a");
      sel_b = 1'b1;
      #1;
      chk_idle_outputs("reset_b");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic sequence; a second start with changed sizes lands while busy.
      run_case(3, 2, 2, -1, -1, 1, 1'b0, 5);
      // Stall on cycles 3..5.
      run_case(3, 2, 2, 3, 5, 1, 1'b0, -1);
      // Zero-sized tile count: immediate done, no reads.
      run_case(3, 0, 2, -1, -1, 1, 1'b0, -1);

      // Reset in the middle of a run.
      sel_b = 1'b0;
      @(posedge clk); #1;
      m2 = 16'd3; m3 = 16'd2; m1 = 16'd2; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_rd_en", o_en, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("post_reset_valid", o_valid, 1'b0);
         chk("post_reset_done", o_done, 1'b0);
         chk("post_reset_rd_en", o_en, 1'b0);
      end

      // Layout loopback: bank data must match the written elements.
      run_case(4, 3, 1, -1, -1, 1, 1'b0, -1);
      // Single-row tiles on the 3-cycle latency instance.
      run_case(1, 2, 2, -1, -1, 3, 1'b1, -1);
      run_case(2, 1, 1, 2, 2, 3, 1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
